alu_pipe_psr: RTL



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_mul_iter.sv | 62 ++++++
 rtl/alu_pipe_psr.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: opcode fields, flag bit positions and
// the internal operation-class selector.
package alu_pkg;

  localparam logic [3:0] MAJ_RTYPE  = 4'b0000;
  localparam logic [3:0] MAJ_ADDI   = 4'b0101;
  localparam logic [3:0] MAJ_SHIFTS = 4'b1000;
  localparam logic [3:0] MAJ_SUBI   = 4'b1001;
  localparam logic [3:0] MAJ_CMPI   = 4'b1011;

  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDC = 4'b0110;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MUL  = 4'b1110;

  localparam logic [3:0] SH_LSHI_L = 4'b0000;
  localparam logic [3:0] SH_LSHI_R = 4'b0001;
  localparam logic [3:0] SH_ASHI_L = 4'b0010;
  localparam logic [3:0] SH_ASHI_R = 4'b0011;
  localparam logic [3:0] SH_LSH    = 4'b0100;
  localparam logic [3:0] SH_ASHU   = 4'b0110;

  localparam int unsigned F_CARRY   = 0;
  localparam int unsigned F_LOW     = 1;
  localparam int unsigned F_OVF     = 2;
  localparam int unsigned F_ZERO    = 3;
  localparam int unsigned F_NEG     = 4;
  localparam int unsigned F_INVALID = 5;

  typedef logic [5:0] flags_t;

  // Operation class: decides which PSR bits an accepted op writes.
  typedef enum logic [2:0] {
    SEL_INV,
    SEL_ZN,
    SEL_ADD,
    SEL_SUB,
    SEL_CMP,
    SEL_MUL
  } op_sel_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done is high on the final cycle, with product already including that step.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_next;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == '0);
  assign product  = acc_next;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_pipe_psr.sv
// Registered ALU with persistent status register, valid/ready handshakes on
// both sides and an iterative multiply that stalls the input while running.
module alu_pipe_psr
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MUL_EN = 1,
  parameter int unsigned SHW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [15:0]      OpCode,
  input  logic             psr_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [5:0]       Flags
);
  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_MUL  = 1'b1;
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q, c_d;
  flags_t           flags_q, flags_d, psr_q, psr_d;

  logic [3:0]       major, ext, sh4;
  logic [WIDTH-1:0] imm, operand, res_lu, res;
  logic [WIDTH:0]   sum, diff;
  logic             cin, accept, mul_start, mul_done, unused_opcode_bits;
  logic [2*WIDTH-1:0] mul_product;
  op_sel_e          sel;
  flags_t           base, nf, mf;

  assign major              = OpCode[15:12];
  assign ext                = OpCode[7:4];
  assign sh4                = OpCode[3:0];
  assign imm                = {{(WIDTH-8){OpCode[7]}}, OpCode[7:0]};
  assign unused_opcode_bits = ^OpCode[11:8];

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // A coinciding psr_clr zeroes every bit the accepted op does not write.
  assign base     = psr_clr ? '0 : psr_q;

  always_comb begin
    sel     = SEL_INV;
    operand = B;
    cin     = 1'b0;
    res_lu  = '0;
    case (major)
      MAJ_RTYPE: begin
        case (ext)
          EXT_AND:  begin sel = SEL_ZN; res_lu = A & B; end
          EXT_OR:   begin sel = SEL_ZN; res_lu = A | B; end
          EXT_XOR:  begin sel = SEL_ZN; res_lu = A ^ B; end
          EXT_ADD:  sel = SEL_ADD;
          EXT_ADDC: begin sel = SEL_ADD; cin = psr_q[F_CARRY]; end
          EXT_SUB:  sel = SEL_SUB;
          EXT_CMP:  sel = SEL_CMP;
          EXT_MUL:  if (MUL_EN != 0) sel = SEL_MUL;
          default:  sel = SEL_INV;
        endcase
      end
      MAJ_ADDI: begin sel = SEL_ADD; operand = imm; end
      MAJ_SUBI: begin sel = SEL_SUB; operand = imm; end
      MAJ_CMPI: begin sel = SEL_CMP; operand = imm; end
      MAJ_SHIFTS: begin
        sel = SEL_ZN;
        case (ext)
          SH_LSHI_L, SH_ASHI_L: res_lu = A << sh4;
          SH_LSHI_R:            res_lu = A >> sh4;
          SH_ASHI_R:            res_lu = $signed(A) >>> sh4;
          SH_LSH:               res_lu = (B >= W_VAL) ? '0 : (A << B[SHW-1:0]);
          SH_ASHU:              res_lu = (B >= W_VAL) ? {WIDTH{A[WIDTH-1]}}
                                                      : ($signed(A) >>> B[SHW-1:0]);
          default:              sel = SEL_INV;
        endcase
      end
      default: sel = SEL_INV;
    endcase
  end

  assign sum  = {1'b0, A} + {1'b0, operand} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, A} - {1'b0, operand};

  always_comb begin
    res = '0;
    nf  = base;
    nf[F_INVALID] = 1'b0;
    case (sel)
      SEL_ZN: begin
        res       = res_lu;
        nf[F_ZERO] = (res_lu == '0);
        nf[F_NEG]  = res_lu[WIDTH-1];
      end
      SEL_ADD: begin
        res         = sum[WIDTH-1:0];
        nf[F_CARRY] = sum[WIDTH];
        nf[F_LOW]   = 1'b0;
        nf[F_OVF]   = (A[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        nf[F_ZERO]  = (sum[WIDTH-1:0] == '0);
        nf[F_NEG]   = sum[WIDTH-1];
      end
      SEL_SUB, SEL_CMP: begin
        res         = (sel == SEL_SUB) ? diff[WIDTH-1:0] : '0;
        nf[F_CARRY] = diff[WIDTH];
        nf[F_OVF]   = (A[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        nf[F_LOW]   = diff[WIDTH-1] ^ nf[F_OVF];
        nf[F_ZERO]  = (diff[WIDTH-1:0] == '0);
        nf[F_NEG]   = diff[WIDTH-1];
      end
      SEL_MUL: res = '0;
      default: nf[F_INVALID] = 1'b1;
    endcase
  end

  always_comb begin
    mf            = base;
    mf[F_INVALID] = 1'b0;
    mf[F_CARRY]   = (mul_product[2*WIDTH-1:WIDTH] != '0);
    mf[F_ZERO]    = (mul_product[WIDTH-1:0] == '0);
    mf[F_NEG]     = mul_product[WIDTH-1];
  end

  assign mul_start = accept && (sel == SEL_MUL);

  if (MUL_EN != 0) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .CLK    (CLK),
      .RESET  (RESET),
      .start  (mul_start),
      .a      (A),
      .b      (B),
      .done   (mul_done),
      .product(mul_product)
    );
  end else begin : g_no_mul
    logic unused_mul_start;
    assign unused_mul_start = mul_start;
    assign mul_done         = 1'b0;
    assign mul_product      = '0;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    flags_d     = flags_q;
    psr_d       = base;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (sel == SEL_MUL) begin
        state_d = ST_MUL;
      end else begin
        out_valid_d = 1'b1;
        c_d         = res;
        flags_d     = nf;
        psr_d       = nf;
      end
    end
    if ((state_q == ST_MUL) && mul_done) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b1;
      c_d         = mul_product[WIDTH-1:0];
      flags_d     = mf;
      psr_d       = mf;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
      psr_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      flags_q     <= flags_d;
      psr_q       <= psr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign C         = c_q;
  assign Flags     = flags_q;

endmodule
